lfsr_range_rng: RTL

Parametrised LFSR random-number source for game-round generation. It produces bounded values in [0, limit] on request through a valid/ready handshake. The LFSR supports configurable width, taps, run-time reseeding and a zero-lock guard. It sits between the round controller, which requests target values, and the display and compare logic that consumes them.

---
 rtl/rng_pkg.sv | 17 +
 rtl/lfsr_core.sv | 39 +++
 rtl/lfsr_range_rng.sv | 116 +++++++++++
 3 files changed

// File: rtl/rng_pkg.sv
// Shared types and constants for the bounded LFSR random-number source.
package rng_pkg;

   typedef enum logic [1:0] {IDLE, DRAW, VALID} rng_state_t;

   localparam logic [4:0]  TAPS_W5  = 5'b10100;
   localparam logic [7:0]  TAPS_W8  = 8'hB8;
   localparam logic [15:0] TAPS_W16 = 16'hB400;

   localparam int unsigned MAX_TRIES_DEFAULT = 16;
   localparam int unsigned TRY_W_DEFAULT     = $clog2(MAX_TRIES_DEFAULT + 1);

   function automatic int unsigned try_cnt_w(input int unsigned max_tries);
      return $clog2(max_tries + 1);
   endfunction

endpackage

// File: rtl/lfsr_core.sv
// Free-running Fibonacci LFSR with run-time reseed and zero-lock recovery.
module lfsr_core
   import rng_pkg::*;
#(
   parameter int unsigned      WIDTH = 5,
   parameter logic [WIDTH-1:0] TAPS  = TAPS_W5,
   parameter logic [WIDTH-1:0] SEED  = 5'b10101
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed,
   output logic [WIDTH-1:0] state
);

   logic [WIDTH-1:0] state_d;
   logic             feedback;

   always_comb begin
      feedback = ^(state & TAPS);
      if (seed_load) begin
         state_d = (seed == '0) ? SEED : seed;
      end else if (state == '0) begin
         // An all-zero register would stick forever; recover to the reset seed.
         state_d = SEED;
      end else begin
         state_d = {state[WIDTH-2:0], feedback};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= SEED;
      end else begin
         state <= state_d;
      end
   end

endmodule

// File: rtl/lfsr_range_rng.sv
// Bounded random values in [0, limit] by rejection sampling an LFSR, with valid/ready output.
module lfsr_range_rng
   import rng_pkg::*;
#(
   parameter int unsigned      WIDTH     = 5,
   parameter logic [WIDTH-1:0] TAPS      = TAPS_W5,
   parameter logic [WIDTH-1:0] SEED      = 5'b10101,
   parameter int unsigned      OUT_W     = 5,
   parameter int unsigned      MAX_TRIES = MAX_TRIES_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed,
   input  logic             req,
   input  logic [OUT_W-1:0] limit,
   output logic             rnd_valid,
   input  logic             rnd_ready,
   output logic [OUT_W-1:0] rnd,
   output logic             busy,
   output logic             fallback
);

   localparam int unsigned TRY_W = try_cnt_w(MAX_TRIES);

   logic [WIDTH-1:0] lfsr_state;
   logic [OUT_W-1:0] cand;
   logic [TRY_W-1:0] try_q;
   logic [TRY_W-1:0] try_nxt;
   rng_state_t       state_q;
   logic [OUT_W-1:0] rnd_q;
   logic             rnd_valid_q;
   logic             busy_q;
   logic             fallback_q;

   lfsr_core #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS),
      .SEED  (SEED)
   ) u_lfsr (
      .clk       (clk),
      .rst       (rst),
      .seed_load (seed_load),
      .seed      (seed),
      .state     (lfsr_state)
   );

   assign cand    = lfsr_state[OUT_W-1:0];
   assign try_nxt = try_q + TRY_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         try_q       <= '0;
         rnd_q       <= '0;
         rnd_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         fallback_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req) begin
                  state_q <= DRAW;
                  try_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            DRAW: begin
               if (seed_load) begin
                  // Reseeding mid-draw abandons the request without producing a value.
                  state_q <= IDLE;
                  try_q   <= '0;
                  busy_q  <= 1'b0;
               end else if (cand <= limit) begin
                  state_q     <= VALID;
                  rnd_q       <= cand;
                  fallback_q  <= 1'b0;
                  rnd_valid_q <= 1'b1;
               end else if (try_nxt == TRY_W'(MAX_TRIES)) begin
                  state_q     <= VALID;
                  try_q       <= try_nxt;
                  rnd_q       <= limit;
                  fallback_q  <= 1'b1;
                  rnd_valid_q <= 1'b1;
               end else begin
                  try_q <= try_nxt;
               end
            end
            VALID: begin
               if (rnd_ready) begin
                  rnd_valid_q <= 1'b0;
                  fallback_q  <= 1'b0;
                  if (req) begin
                     state_q <= DRAW;
                     try_q   <= '0;
                  end else begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end
            end
            default: begin
               state_q     <= IDLE;
               busy_q      <= 1'b0;
               rnd_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign rnd       = rnd_q;
   assign rnd_valid = rnd_valid_q;
   assign busy      = busy_q;
   assign fallback  = fallback_q;

endmodule
